// File: rtl/codma_pkg.sv
// Shared types and constants for the codma descriptor fetch front end.
package codma_pkg;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        BURST  = 2'd1,
        LINK   = 2'd2
    } task_type_e;

    // Word 0 carries type/src, word 1 carries dst/len; type is kept at full
    // width so that out-of-range encodings remain visible to the validator.
    typedef struct packed {
        logic [31:0] type_raw;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } codma_desc_t;

    localparam int unsigned MEM_BYTES   = 32 * 8;
    localparam logic [31:0] LINK_STRIDE = 32'd32;
    localparam logic        STATUS_OK   = 1'b0;
    localparam logic        STATUS_ERR  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD0,
        ST_W0,
        ST_RD1,
        ST_W1,
        ST_CHECK,
        ST_ISSUE,
        ST_XFER,
        ST_STAT,
        ST_DONE
    } fetch_state_e;

    // A 16-byte descriptor fits only if its last byte is inside memory.
    function automatic logic desc_in_mem(input logic [31:0] ptr,
                                         input logic [32:0] mem_bytes);
        return ({1'b0, ptr} + 33'd15) < mem_bytes;
    endfunction

endpackage

// File: rtl/codma_desc_check.sv
// Combinational descriptor validator: type, length, alignment and bounds.
module codma_desc_check
    import codma_pkg::*;
#(
    parameter int unsigned MEM_BYTES_P = MEM_BYTES
) (
    input  codma_desc_t desc_i,
    output logic        ok_o
);

    localparam logic [32:0] LIMIT = 33'(MEM_BYTES_P);

    logic [32:0] src_end;
    logic [32:0] dst_end;
    logic        type_ok;
    logic        len_ok;
    logic        align_ok;

    always_comb begin
        // Ends are formed at 33 bits so a 32-bit wrap reads as overflow.
        src_end  = {1'b0, desc_i.src} + {1'b0, desc_i.len};
        dst_end  = {1'b0, desc_i.dst} + {1'b0, desc_i.len};
        type_ok  = desc_i.type_raw <= 32'(LINK);
        len_ok   = desc_i.len != 32'd0;
        align_ok = (desc_i.type_raw == 32'(SINGLE)) ? (desc_i.len[2:0] == 3'd0)
                                                    : (desc_i.len[4:0] == 5'd0);
        ok_o     = type_ok && len_ok && align_ok &&
                   (src_end <= LIMIT) && (dst_end <= LIMIT);
    end

endmodule

// File: rtl/codma_task_fetch.sv
// Descriptor fetch/sequencer for codma; optional perf counters behind
// CODMA_FETCH_PERF_EN.
module codma_task_fetch
    import codma_pkg::*;
#(
    parameter int MEM_DEPTH = 32,
    parameter int MEM_WIDTH = 8,
    parameter int MAX_LINKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] task_pointer_i,
    input  logic [31:0] status_pointer_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_gnt_i,
    input  logic        rd_valid_i,
    input  logic [63:0] rd_data_i,
    output logic        wr_req_o,
    output logic [31:0] wr_addr_o,
    output logic [63:0] wr_data_o,
    input  logic        wr_gnt_i,
    output logic        desc_valid_o,
    input  logic        desc_ready_i,
    output logic [1:0]  desc_type_o,
    output logic [31:0] desc_src_o,
    output logic [31:0] desc_dst_o,
    output logic [31:0] desc_len_o,
    input  logic        xfer_done_i,
    input  logic        xfer_err_i
`ifdef CODMA_FETCH_PERF_EN
    ,
    output logic [15:0] perf_desc_cnt_o,
    output logic [31:0] perf_busy_cyc_o
`endif
);

    localparam int unsigned        MEM_SIZE = MEM_DEPTH * MEM_WIDTH;
    localparam logic [32:0]        MEM_LIM  = 33'(MEM_SIZE);
    localparam int                 CNT_W    = $clog2(MAX_LINKS + 1);
    localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_LINKS);
    localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [31:0]      stat_ptr_q, stat_ptr_d;
    codma_desc_t      desc_q, desc_d;
    logic [CNT_W-1:0] link_cnt_q, link_cnt_d;
    logic             status_q, status_d;

    logic [31:0]      start_ptr;
    logic [31:0]      link_ptr;
    logic             desc_ok;

    assign start_ptr = task_pointer_i & ~32'h7;
    assign link_ptr  = ptr_q + LINK_STRIDE;

    codma_desc_check #(
        .MEM_BYTES_P (MEM_SIZE)
    ) u_check (
        .desc_i (desc_q),
        .ok_o   (desc_ok)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            stat_ptr_q <= '0;
            desc_q     <= '0;
            link_cnt_q <= '0;
            status_q   <= STATUS_OK;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            stat_ptr_q <= stat_ptr_d;
            desc_q     <= desc_d;
            link_cnt_q <= link_cnt_d;
            status_q   <= status_d;
        end
    end

    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        stat_ptr_d = stat_ptr_q;
        desc_d     = desc_q;
        link_cnt_d = link_cnt_q;
        status_d   = status_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    ptr_d      = start_ptr;
                    stat_ptr_d = status_pointer_i & ~32'h7;
                    link_cnt_d = ONE_CNT;
                    status_d   = STATUS_OK;
                    if (desc_in_mem(start_ptr, MEM_LIM)) begin
                        state_d = ST_RD0;
                    end else begin
                        status_d = STATUS_ERR;
                        state_d  = ST_STAT;
                    end
                end
            end
            ST_RD0: if (rd_gnt_i) state_d = ST_W0;
            ST_W0: begin
                if (rd_valid_i) begin
                    desc_d.type_raw = rd_data_i[31:0];
                    desc_d.src      = rd_data_i[63:32];
                    state_d         = ST_RD1;
                end
            end
            ST_RD1: if (rd_gnt_i) state_d = ST_W1;
            ST_W1: begin
                if (rd_valid_i) begin
                    desc_d.dst = rd_data_i[31:0];
                    desc_d.len = rd_data_i[63:32];
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (desc_ok) begin
                    state_d = ST_ISSUE;
                end else begin
                    status_d = STATUS_ERR;
                    state_d  = ST_STAT;
                end
            end
            ST_ISSUE: if (desc_ready_i) state_d = ST_XFER;
            ST_XFER: begin
                if (xfer_done_i) begin
                    state_d = ST_STAT;
                    if (xfer_err_i) begin
                        status_d = STATUS_ERR;
                    end else if (desc_q.type_raw == 32'(LINK)) begin
                        // Follow the chain only while under the link budget and
                        // while the next descriptor lies inside memory.
                        if (link_cnt_q < MAX_CNT && desc_in_mem(link_ptr, MEM_LIM)) begin
                            ptr_d      = link_ptr;
                            link_cnt_d = link_cnt_q + ONE_CNT;
                            state_d    = ST_RD0;
                        end else begin
                            status_d = STATUS_ERR;
                        end
                    end else begin
                        status_d = STATUS_OK;
                    end
                end
            end
            ST_STAT: if (wr_gnt_i) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = state_q != ST_IDLE;
        done_o       = state_q == ST_DONE;
        error_o      = (state_q == ST_DONE) && status_q;
        rd_req_o     = (state_q == ST_RD0) || (state_q == ST_RD1);
        rd_addr_o    = (state_q == ST_RD0) ? ptr_q :
                       (state_q == ST_RD1) ? ptr_q + 32'd8 : 32'd0;
        wr_req_o     = state_q == ST_STAT;
        wr_addr_o    = wr_req_o ? stat_ptr_q : 32'd0;
        wr_data_o    = wr_req_o ? {63'd0, status_q} : 64'd0;
        desc_valid_o = state_q == ST_ISSUE;
        desc_type_o  = desc_valid_o ? desc_q.type_raw[1:0] : 2'd0;
        desc_src_o   = desc_valid_o ? desc_q.src : 32'd0;
        desc_dst_o   = desc_valid_o ? desc_q.dst : 32'd0;
        desc_len_o   = desc_valid_o ? desc_q.len : 32'd0;
    end

`ifdef CODMA_FETCH_PERF_EN
    logic [15:0] perf_desc_q;
    logic [31:0] perf_busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_desc_q <= '0;
            perf_busy_q <= '0;
        end else begin
            if (desc_valid_o && desc_ready_i && perf_desc_q != '1) begin
                perf_desc_q <= perf_desc_q + 16'd1;
            end
            if (busy_o && perf_busy_q != '1) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
        end
    end

    assign perf_desc_cnt_o = perf_desc_q;
    assign perf_busy_cyc_o = perf_busy_q;
`endif

endmodule

// File: tb/tb_codma_task_fetch.sv
// Directed bench for codma_task_fetch with memory, copy-engine and status-write
// responders.
module tb_codma_task_fetch;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [31:0] task_pointer_i;
    logic [31:0] status_pointer_i;
    logic        busy_o, done_o, error_o;
    logic        rd_req_o;
    logic [31:0] rd_addr_o;
    logic        rd_gnt_i, rd_valid_i;
    logic [63:0] rd_data_i;
    logic        wr_req_o;
    logic [31:0] wr_addr_o;
    logic [63:0] wr_data_o;
    logic        wr_gnt_i;
    logic        desc_valid_o, desc_ready_i;
    logic [1:0]  desc_type_o;
    logic [31:0] desc_src_o, desc_dst_o, desc_len_o;
    logic        xfer_done_i, xfer_err_i;
`ifdef CODMA_FETCH_PERF_EN
    logic [15:0] perf_desc_cnt_o;
    logic [31:0] perf_busy_cyc_o;
`endif

    codma_task_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start_i),
        .task_pointer_i   (task_pointer_i),
        .status_pointer_i (status_pointer_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .rd_req_o         (rd_req_o),
        .rd_addr_o        (rd_addr_o),
        .rd_gnt_i         (rd_gnt_i),
        .rd_valid_i       (rd_valid_i),
        .rd_data_i        (rd_data_i),
        .wr_req_o         (wr_req_o),
        .wr_addr_o        (wr_addr_o),
        .wr_data_o        (wr_data_o),
        .wr_gnt_i         (wr_gnt_i),
        .desc_valid_o     (desc_valid_o),
        .desc_ready_i     (desc_ready_i),
        .desc_type_o      (desc_type_o),
        .desc_src_o       (desc_src_o),
        .desc_dst_o       (desc_dst_o),
        .desc_len_o       (desc_len_o),
        .xfer_done_i      (xfer_done_i),
        .xfer_err_i       (xfer_err_i)
`ifdef CODMA_FETCH_PERF_EN
        ,
        .perf_desc_cnt_o  (perf_desc_cnt_o),
        .perf_busy_cyc_o  (perf_busy_cyc_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;
    int first_valid_cyc;
    int done_cnt = 0;
    logic last_err;

    logic [63:0] mem [32];
    int   gnt_delay, ready_delay, xfer_delay;
    logic xfer_err_cfg;

    logic [31:0] rd_log[$];
    logic [97:0] cmd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [63:0] wr_data_log[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory read port: grant after gnt_delay cycles, data one cycle later.
    initial begin
        int          gwait;
        logic        vpend;
        logic        prev_wait;
        logic [31:0] paddr, prev_addr;
        gwait = 0; vpend = 1'b0; prev_wait = 1'b0; paddr = '0; prev_addr = '0;
        rd_gnt_i = 1'b0; rd_valid_i = 1'b0; rd_data_i = '0;
        forever begin
            @(negedge clk);
            rd_gnt_i   = 1'b0;
            rd_valid_i = 1'b0;
            if (reset) begin
                gwait = 0; vpend = 1'b0; prev_wait = 1'b0;
            end else if (vpend) begin
                rd_valid_i = 1'b1;
                rd_data_i  = mem[paddr[7:3]];
                vpend      = 1'b0;
            end else if (rd_req_o) begin
                if (prev_wait) check("rd_addr_stable", rd_addr_o, prev_addr);
                if (gwait < gnt_delay) begin
                    gwait++;
                    prev_wait = 1'b1;
                    prev_addr = rd_addr_o;
                end else begin
                    rd_gnt_i  = 1'b1;
                    gwait     = 0;
                    prev_wait = 1'b0;
                    vpend     = 1'b1;
                    paddr     = rd_addr_o;
                    rd_log.push_back(rd_addr_o);
                end
            end else if (prev_wait) begin
                check("rd_req_held", rd_req_o, 1'b1);
                prev_wait = 1'b0;
            end
        end
    end

    // Copy engine: accept after ready_delay cycles, finish xfer_delay later.
    initial begin
        int          rwait, dcnt;
        logic        busy_x;
        logic [97:0] seen, cur;
        rwait = 0; dcnt = 0; busy_x = 1'b0; seen = '0;
        desc_ready_i = 1'b0; xfer_done_i = 1'b0; xfer_err_i = 1'b0;
        forever begin
            @(negedge clk);
            desc_ready_i = 1'b0;
            xfer_done_i  = 1'b0;
            xfer_err_i   = 1'b0;
            if (reset) begin
                busy_x = 1'b0; rwait = 0;
            end else if (busy_x) begin
                dcnt++;
                if (dcnt >= xfer_delay) begin
                    xfer_done_i = 1'b1;
                    xfer_err_i  = xfer_err_cfg;
                    busy_x      = 1'b0;
                end
            end else if (desc_valid_o) begin
                cur = {desc_type_o, desc_src_o, desc_dst_o, desc_len_o};
                if (rwait == 0) begin
                    seen = cur;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end else begin
                    check("desc_stable", cur, seen);
                end
                if (rwait < ready_delay) begin
                    rwait++;
                end else begin
                    desc_ready_i = 1'b1;
                    cmd_log.push_back(cur);
                    rwait  = 0;
                    busy_x = 1'b1;
                    dcnt   = 0;
                end
            end
        end
    end

    // Status write port (immediate grant) and done monitor.
    initial begin
        wr_gnt_i = 1'b0;
        forever begin
            @(negedge clk);
            wr_gnt_i = 1'b0;
            if (!reset && wr_req_o) begin
                wr_addr_log.push_back(wr_addr_o);
                wr_data_log.push_back(wr_data_o);
                wr_gnt_i = 1'b1;
            end
            if (done_o) begin
                done_cnt++;
                last_err = error_o;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        cmd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        first_valid_cyc = -1;
    endtask

    task automatic run(input string tag, input logic [31:0] tp, input logic [31:0] sp);
        int d0;
        clear_logs();
        d0 = done_cnt;
        @(negedge clk);
        task_pointer_i   = tp;
        status_pointer_i = sp;
        start_i          = 1'b1;
        start_cyc        = cyc;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_busy"}, busy_o, 1'b1);
        for (int i = 0; i < 600 && done_cnt == d0; i++) @(negedge clk);
        check({tag, "_done_seen"}, done_cnt != d0, 1'b1);
        @(negedge clk);
        check({tag, "_idle"}, busy_o, 1'b0);
    endtask

    task automatic expect_status(input string tag, input logic [31:0] addr, input logic st);
        check({tag, "_wr_count"}, wr_addr_log.size(), 1);
        check({tag, "_wr_addr"}, (wr_addr_log.size() > 0) ? wr_addr_log[0] : 32'hDEAD_BEEF, addr);
        check({tag, "_wr_data"}, (wr_data_log.size() > 0) ? wr_data_log[0] : 64'hDEAD, {63'd0, st});
        check({tag, "_error"}, last_err, st);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0;
        task_pointer_i = '0; status_pointer_i = '0;
        gnt_delay = 0; ready_delay = 0; xfer_delay = 2; xfer_err_cfg = 1'b0;
        last_err = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_outs", {done_o, error_o, rd_req_o, wr_req_o, desc_valid_o}, 5'd0);
        check("rst_addr", {rd_addr_o, wr_addr_o, desc_src_o}, 96'd0);
        reset = 1'b0;

        // Single descriptor, unaligned pointers forced to 8-byte alignment.
        mem[0] = {32'd64, 32'd0};
        mem[1] = {32'd16, 32'd128};
        run("t1", 32'h3, 32'hF5);
        check("t1_latency", first_valid_cyc - start_cyc, 6);
        check("t1_cmd_count", cmd_log.size(), 1);
        check("t1_cmd0", (cmd_log.size() > 0) ? cmd_log[0] : '1, {2'd0, 32'd64, 32'd128, 32'd16});
        check("t1_reads", {rd_log.size(), (rd_log.size() > 1) ? rd_log[1] : 32'hFFFF_FFFF}, {32'd2, 32'd8});
        expect_status("t1", 32'hF0, 1'b0);

        // Two-entry chain.
        clear_mem();
        mem[0] = {32'd8, 32'd2};
        mem[1] = {32'd32, 32'd96};
        mem[4] = {32'd0, 32'd0};
        mem[5] = {32'd24, 32'd160};
        run("t2", 32'd0, 32'hF8);
        check("t2_cmd_count", cmd_log.size(), 2);
        check("t2_cmd0", (cmd_log.size() > 0) ? cmd_log[0] : '1, {2'd2, 32'd8, 32'd96, 32'd32});
        check("t2_cmd1", (cmd_log.size() > 1) ? cmd_log[1] : '1, {2'd0, 32'd0, 32'd160, 32'd24});
        check("t2_rd_count", rd_log.size(), 4);
        check("t2_rd_addrs", (rd_log.size() == 4) ? {rd_log[0], rd_log[1], rd_log[2], rd_log[3]} : '1,
              {32'd0, 32'd8, 32'd32, 32'd40});
        expect_status("t2", 32'hF8, 1'b0);

        // Source overflow: 200 + 64 = 264 > 256.
        clear_mem();
        mem[0] = {32'd200, 32'd1};
        mem[1] = {32'd64, 32'd0};
        run("t3", 32'd0, 32'hF0);
        check("t3_cmd_count", cmd_log.size(), 0);
        expect_status("t3", 32'hF0, 1'b1);

        // Five linked descriptors; only four may be processed.
        clear_mem();
        for (int i = 0; i < 5; i++) begin
            mem[4*i]   = {32'd0, 32'd2};
            mem[4*i+1] = {32'd32, 32'd0};
        end
        run("t4", 32'd0, 32'hF0);
        check("t4_cmd_count", cmd_log.size(), 4);
        check("t4_rd_count", rd_log.size(), 8);
        check("t4_rd_last", (rd_log.size() > 7) ? rd_log[7] : 32'hFFFF_FFFF, 32'd104);
        expect_status("t4", 32'hF0, 1'b1);

        // Slow grant and ready with a copy-engine error.
        clear_mem();
        mem[0] = {32'd64, 32'd0};
        mem[1] = {32'd16, 32'd128};
        gnt_delay = 3; ready_delay = 5; xfer_err_cfg = 1'b1;
        run("t5", 32'd0, 32'hE0);
        check("t5_cmd_count", cmd_log.size(), 1);
        check("t5_cmd0", (cmd_log.size() > 0) ? cmd_log[0] : '1, {2'd0, 32'd64, 32'd128, 32'd16});
        expect_status("t5", 32'hE0, 1'b1);
        gnt_delay = 0; ready_delay = 0; xfer_err_cfg = 1'b0;

        // Descriptor straddles the end of memory: 248 + 15 > 255, no fetch.
        run("t7", 32'd248, 32'hF0);
        check("t7_rd_count", rd_log.size(), 0);
        expect_status("t7", 32'hF0, 1'b1);

        // Exact-fit burst (224 + 32 = 256) passes; misaligned single fails.
        clear_mem();
        mem[0] = {32'd224, 32'd1};
        mem[1] = {32'd32, 32'd224};
        mem[8] = {32'd0, 32'd0};
        mem[9] = {32'd12, 32'd0};
        run("t8", 32'd0, 32'hF0);
        check("t8_cmd0", (cmd_log.size() > 0) ? cmd_log[0] : '1, {2'd1, 32'd224, 32'd224, 32'd32});
        expect_status("t8", 32'hF0, 1'b0);
        run("t9", 32'd64, 32'hF0);
        check("t9_cmd_count", cmd_log.size(), 0);
        expect_status("t9", 32'hF0, 1'b1);

        // Reset while the copy engine is busy.
        clear_mem();
        mem[0] = {32'd64, 32'd0};
        mem[1] = {32'd16, 32'd128};
        xfer_delay = 20;
        clear_logs();
        begin
            int d0;
            d0 = done_cnt;
            @(negedge clk);
            task_pointer_i = 32'd0; status_pointer_i = 32'hF0; start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            for (int i = 0; i < 100 && cmd_log.size() == 0; i++) @(negedge clk);
            check("t6_cmd_accepted", cmd_log.size(), 1);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("t6_rst_idle", busy_o, 1'b0);
            check("t6_rst_wr_req", wr_req_o, 1'b0);
            @(negedge clk);
            reset = 1'b0;
            repeat (30) @(negedge clk);
            check("t6_no_write", wr_addr_log.size(), 0);
            check("t6_no_done", done_cnt - d0, 0);
        end
        xfer_delay = 2;
        run("t6b", 32'd0, 32'hF0);
        check("t6b_cmd_count", cmd_log.size(), 1);
        expect_status("t6b", 32'hF0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
